// File: rtl/operand_fetch_pkg.sv
// Shared widths and operand-select encoding for the operand fetch stage.
package operand_fetch_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    typedef enum logic {
        OPSEL_REG = 1'b0,
        OPSEL_IMM = 1'b1
    } opsel_e;

endpackage

// File: rtl/regfile.sv
// Register file: two asynchronous read ports and one write port.
// Register 0 is hardwired to zero.
module regfile #(
    parameter int DATA_WIDTH = operand_fetch_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = operand_fetch_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // NOTE: the array is reset because the architecture requires every
    // register to read zero after reset; this forces flops, not RAM macros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources with write-back bypass and presents
// them to the ALU through a valid/ready output register.
module operand_fetch #(
    parameter int DATA_WIDTH = operand_fetch_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = operand_fetch_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  ALUsrc,
    input  logic                  ALUctrl_in,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic                  ALUctrl,
    output logic [ADDR_WIDTH-1:0] rd_out
);

    logic [DATA_WIDTH-1:0]     rf_data1;
    logic [DATA_WIDTH-1:0]     rf_data2;
    logic [DATA_WIDTH-1:0]     op1_next;
    logic [DATA_WIDTH-1:0]     op2_next;
    logic                      accept;
    logic                      holding;
    logic                      wb_live;
    operand_fetch_pkg::opsel_e sel_in;
    operand_fetch_pkg::opsel_e held_sel;
    logic [ADDR_WIDTH-1:0]     held_rs1;
    logic [ADDR_WIDTH-1:0]     held_rs2;

    regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rd_addr_a(rs1),
        .rd_data_a(rf_data1),
        .rd_addr_b(rs2),
        .rd_data_b(rf_data2)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign holding  = out_valid && !out_ready;
    assign wb_live  = wb_en && (wb_addr != '0);
    assign sel_in   = operand_fetch_pkg::opsel_e'(ALUsrc);

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        op1_next = rf_data1;
        op2_next = rf_data2;
        if (wb_live && (wb_addr == rs1)) op1_next = wb_data;
        if (wb_live && (wb_addr == rs2)) op2_next = wb_data;
        if (sel_in == operand_fetch_pkg::OPSEL_IMM) op2_next = imm;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ALUop1    <= '0;
            ALUop2    <= '0;
            ALUctrl   <= 1'b0;
            rd_out    <= '0;
            held_rs1  <= '0;
            held_rs2  <= '0;
            held_sel  <= operand_fetch_pkg::OPSEL_REG;
        end else if (accept) begin
            out_valid <= 1'b1;
            ALUop1    <= op1_next;
            ALUop2    <= op2_next;
            ALUctrl   <= ALUctrl_in;
            rd_out    <= rd;
            held_rs1  <= rs1;
            held_rs2  <= rs2;
            held_sel  <= sel_in;
        end else if (holding) begin
            // A stalled operation must not go stale behind a later write-back.
            if (wb_live && (wb_addr == held_rs1)) ALUop1 <= wb_data;
            if (wb_live && (wb_addr == held_rs2) && (held_sel == operand_fetch_pkg::OPSEL_REG))
                ALUop2 <= wb_data;
        end else if (out_valid) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vectors plus random traffic
// compared against a cycle-level behavioural model.
module tb_operand_fetch;

    localparam int DW = 12;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, alu_src, alu_ctrl_in, wb_en;
    logic [AW-1:0] rs1, rs2, rd, wb_addr, rd_out;
    logic [DW-1:0] imm, wb_data, alu_op1, alu_op2;
    logic          out_valid, out_ready, alu_ctrl;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [DW-1:0] m_reg [32];
    logic          m_valid, m_ctrl, m_src;
    logic [DW-1:0] m_op1, m_op2;
    logic [AW-1:0] m_rd, m_rs1, m_rs2;

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .ALUsrc    (alu_src),
        .ALUctrl_in(alu_ctrl_in),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUop1    (alu_op1),
        .ALUop2    (alu_op2),
        .ALUctrl   (alu_ctrl),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_valid = 1'b0; m_ctrl = 1'b0; m_src = 1'b0;
        m_op1 = '0; m_op2 = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    endtask

    // Value a source index reads in the current cycle, including bypass.
    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_reg[a];
    endfunction

    task automatic model_step();
        logic acc;
        acc = in_valid && (!m_valid || out_ready);
        if (acc) begin
            m_op1 = m_read(rs1);
            m_op2 = alu_src ? imm : m_read(rs2);
            m_ctrl = alu_ctrl_in; m_rd = rd; m_rs1 = rs1; m_rs2 = rs2; m_src = alu_src;
            m_valid = 1'b1;
        end else if (m_valid && !out_ready) begin
            if (wb_en && wb_addr != 0 && wb_addr == m_rs1) m_op1 = wb_data;
            if (!m_src && wb_en && wb_addr != 0 && wb_addr == m_rs2) m_op2 = wb_data;
        end else begin
            m_valid = 1'b0;
        end
        if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".op1"}, 32'(alu_op1), 32'(m_op1));
        check({tag, ".op2"}, 32'(alu_op2), 32'(m_op2));
        check({tag, ".ctrl"}, 32'(alu_ctrl), 32'(m_ctrl));
        check({tag, ".rd_out"}, 32'(rd_out), 32'(m_rd));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(input string tag);
        #1 check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
        @(posedge clk);
        model_step();
        #1 check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic set_in(input logic iv, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [AW-1:0] d, input logic [DW-1:0] im, input logic src,
                          input logic ctl, input logic we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic ordy);
        in_valid = iv; rs1 = a1; rs2 = a2; rd = d; imm = im; alu_src = src;
        alu_ctrl_in = ctl; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // write r3, r4 then read both as registers
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 12'h0A5, 1); tick("wr3");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 4, 12'h00F, 1); tick("wr4");
        set_in(1, 3, 4, 7, 12'h555, 0, 1, 0, 0, 0, 1); tick("acc34");
        check("v032.valid", 32'(out_valid), 32'd1);
        check("v032.op1", 32'(alu_op1), 32'h0A5);
        check("v032.op2", 32'(alu_op2), 32'h00F);

        // immediate operand, then write to r0 is ignored
        set_in(1, 3, 4, 2, 12'hFFF, 1, 0, 1, 0, 12'h123, 1); tick("imm");
        check("v033.op1", 32'(alu_op1), 32'h0A5);
        check("v033.op2", 32'(alu_op2), 32'hFFF);
        set_in(1, 0, 0, 1, 12'h000, 1, 0, 0, 0, 0, 1); tick("rd0");
        check("v033.r0", 32'(alu_op1), 32'h000);

        // same-cycle write-back bypass
        set_in(1, 5, 0, 3, 12'h001, 1, 1, 1, 5, 12'h7C1, 1); tick("byp");
        check("v034.op1", 32'(alu_op1), 32'h7C1);

        // hold with a write-back to the held rs2
        set_in(1, 3, 4, 6, 12'h0, 0, 0, 0, 0, 0, 1); tick("acc_hold");
        set_in(1, 1, 2, 9, 12'h0, 0, 1, 1, 4, 12'h222, 0); tick("hold_wb");
        check("v035.op2", 32'(alu_op2), 32'h222);
        check("v035.valid", 32'(out_valid), 32'd1);
        check("v035.in_ready", 32'(in_ready), 32'd0);
        check("v035.rd_out", 32'(rd_out), 32'd6);

        // four back-to-back ops, no bubble
        for (int i = 0; i < 4; i++) begin
            set_in(1, AW'(i + 2), AW'(i + 3), AW'(i), DW'(i * 17), 1'(i & 1), 1'(i), 0, 0, 0, 1);
            tick("b2b");
            check("v036.valid", 32'(out_valid), 32'd1);
            check("v036.rd_out", 32'(rd_out), 32'(i));
        end

        // random traffic on a narrow index range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                   AW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
                   1'($urandom_range(0, 2) != 0));
            tick("rnd");
        end

        // asynchronous reset mid-operation
        set_in(1, 5, 0, 8, 12'hABC, 1, 1, 0, 0, 0, 0); tick("pre_rst");
        check("v037.pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("v037.valid", 32'(out_valid), 32'd0);
        check("v037.op1", 32'(alu_op1), 32'd0);
        check("v037.op2", 32'(alu_op2), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 3, 4, 1, 12'h0, 0, 0, 0, 0, 0, 1); tick("post_rst");
        check("v037.valid_after", 32'(out_valid), 32'd1);
        check("v037.r3", 32'(alu_op1), 32'd0);
        check("v037.r4", 32'(alu_op2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
